// File: rtl/fpnew_issue_rob.sv
// fpnew_issue_rob: issue controller and reorder buffer in front of an FPnew FPU.
// It allocates one tag per accepted command and collects tagged FPU results in
// any order. Responses are returned to the requester strictly in issue order,
// and sticky IEEE exception flags are accumulated as responses retire.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cmd_*                      command stream from the requester (valid/ready)
//   fpu_in_valid_o/ready_i     FPU input handshake; operands/op/tag to the FPU
//   fpu_out_valid_i/ready_o    FPU output handshake; result/status/tag from the FPU
//   fpu_flush_o                flush request to the FPU
//   rsp_*                      in-order response stream (valid/ready)
//   flush_i                    discard all outstanding work
//   fflags_o, fflags_clr_i     sticky {NV,DZ,OF,UF,NX} flags and their clear
//   busy_o                     at least one entry outstanding
module fpnew_issue_rob #(
    parameter int unsigned FLEN      = 16,
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [3*FLEN-1:0]    cmd_operands_i,
    input  logic [3:0]           cmd_op_i,
    input  logic                 cmd_op_mod_i,
    input  logic [2:0]           cmd_rnd_i,
    output logic                 fpu_in_valid_o,
    input  logic                 fpu_in_ready_i,
    output logic [3*FLEN-1:0]    fpu_operands_o,
    output logic [3:0]           fpu_op_o,
    output logic                 fpu_op_mod_o,
    output logic [2:0]           fpu_rnd_mode_o,
    output logic [TAG_WIDTH-1:0] fpu_tag_o,
    output logic                 fpu_flush_o,
    input  logic                 fpu_out_valid_i,
    output logic                 fpu_out_ready_o,
    input  logic [FLEN-1:0]      fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic [TAG_WIDTH-1:0] fpu_tag_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [FLEN-1:0]      rsp_result_o,
    output logic [4:0]           rsp_status_o,
    input  logic                 flush_i,
    output logic [4:0]           fflags_o,
    input  logic                 fflags_clr_i,
    output logic                 busy_o
);
    localparam int unsigned        DEPTH      = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);
    localparam logic [TAG_WIDTH:0] PTR_ONE    = {{TAG_WIDTH{1'b0}}, 1'b1};

    logic [TAG_WIDTH:0]   head_q, tail_q, count;
    logic [TAG_WIDTH-1:0] head_idx, tail_idx, cpl_offset;
    logic [DEPTH-1:0]     done_q, done_d;
    logic [FLEN-1:0]      result_q [DEPTH];
    logic [4:0]           status_q [DEPTH];
    logic [4:0]           fflags_q;
    logic                 issue_ok, issue_fire, cpl_fire, rsp_fire;

    assign head_idx = head_q[TAG_WIDTH-1:0];
    assign tail_idx = tail_q[TAG_WIDTH-1:0];
    assign count    = tail_q - head_q;

    // Issue: purely combinational path from command to FPU.
    assign issue_ok       = rst_ni & cmd_valid_i & (count != FULL_COUNT) & ~flush_i;
    assign fpu_in_valid_o = issue_ok;
    assign cmd_ready_o    = issue_ok & fpu_in_ready_i;
    assign issue_fire     = cmd_ready_o;
    assign fpu_tag_o      = tail_idx;
    assign fpu_operands_o = cmd_operands_i;
    assign fpu_op_o       = cmd_op_i;
    assign fpu_op_mod_o   = cmd_op_mod_i;
    assign fpu_rnd_mode_o = cmd_rnd_i;
    assign fpu_flush_o    = rst_ni & flush_i;

    // Every issued command owns a slot, so results can always be accepted.
    assign fpu_out_ready_o = rst_ni;

    // A tag is outstanding when its distance from head is below count;
    // anything else is a stale or spurious result and is dropped.
    assign cpl_offset = fpu_tag_i - head_idx;
    assign cpl_fire   = fpu_out_valid_i & ~flush_i & ({1'b0, cpl_offset} < count);

    // Retire from the head entry only.
    assign rsp_valid_o  = done_q[head_idx];
    assign rsp_result_o = result_q[head_idx];
    assign rsp_status_o = status_q[head_idx];
    assign rsp_fire     = rsp_valid_o & rsp_ready_i & ~flush_i;

    assign fflags_o = fflags_q;
    assign busy_o   = (count != '0);

    // Completion is applied after the retire clear; the two never target the
    // same live entry, since a completed head is not reported again.
    always_comb begin
        done_d = done_q;
        if (rsp_fire) done_d[head_idx] = 1'b0;
        if (cpl_fire) done_d[fpu_tag_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
        end else if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
        end else begin
            if (issue_fire) tail_q <= tail_q + PTR_ONE;
            if (rsp_fire)   head_q <= head_q + PTR_ONE;
            done_q <= done_d;
        end
    end

    // Payload storage needs no reset: it is only observed behind a done bit.
    always_ff @(posedge clk_i) begin
        if (cpl_fire) begin
            result_q[fpu_tag_i] <= fpu_result_i;
            status_q[fpu_tag_i] <= fpu_status_i;
        end
    end

    // A clear still keeps the status of a retire in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else if (fflags_clr_i) begin
            fflags_q <= rsp_fire ? rsp_status_o : '0;
        end else if (rsp_fire) begin
            fflags_q <= fflags_q | rsp_status_o;
        end
    end
endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Testbench for fpnew_issue_rob: a behavioural FPU model answers commands in
// random or chosen order, a scoreboard queue holds expected in-order responses,
// and a negedge monitor compares every DUT output against the model state.
module tb_fpnew_issue_rob;
    localparam int FLEN  = 16;
    localparam int TW    = 2;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cmd_valid_i = 1'b0, cmd_ready_o;
    logic [47:0]     cmd_operands_i = '0;
    logic [3:0]      cmd_op_i = '0;
    logic            cmd_op_mod_i = 1'b0;
    logic [2:0]      cmd_rnd_i = '0;
    logic            fpu_in_valid_o, fpu_in_ready_i = 1'b1;
    logic [47:0]     fpu_operands_o;
    logic [3:0]      fpu_op_o;
    logic            fpu_op_mod_o;
    logic [2:0]      fpu_rnd_mode_o;
    logic [TW-1:0]   fpu_tag_o;
    logic            fpu_flush_o;
    logic            fpu_out_valid_i = 1'b0, fpu_out_ready_o;
    logic [15:0]     fpu_result_i = '0;
    logic [4:0]      fpu_status_i = '0;
    logic [TW-1:0]   fpu_tag_i = '0;
    logic            rsp_valid_o, rsp_ready_i = 1'b1;
    logic [15:0]     rsp_result_o;
    logic [4:0]      rsp_status_o;
    logic            flush_i = 1'b0;
    logic [4:0]      fflags_o;
    logic            fflags_clr_i = 1'b0;
    logic            busy_o;

    always #5 clk = ~clk;

    fpnew_issue_rob #(.FLEN(16), .TAG_WIDTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_operands_i(cmd_operands_i), .cmd_op_i(cmd_op_i),
        .cmd_op_mod_i(cmd_op_mod_i), .cmd_rnd_i(cmd_rnd_i),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
        .fpu_op_mod_o(fpu_op_mod_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
        .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .flush_i(flush_i), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .busy_o(busy_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  tag;
        logic [15:0] res;
        logic [4:0]  st;
    } ent_t;

    ent_t       exp_q[$];
    ent_t       fpu_q[$];
    logic [3:0] done_m = '0;
    logic [4:0] ff_m = '0;
    logic [1:0] tag_m = '0;
    logic       mon_en = 1'b0;
    logic       fpu_hold = 1'b1;
    int         fpu_pick = -1;
    logic       fpu_force = 1'b0;
    logic [1:0] force_tag = '0;

    // Stand-in FPU arithmetic: op 2 is a half-precision magnitude add with
    // truncation; every other op is a fixed mix with status taken from c[4:0].
    function automatic logic [20:0] fpu_fn(input logic [47:0] ops, input logic [3:0] op,
                                           input logic md, input logic [2:0] rnd);
        logic [15:0] a, b, c, res;
        logic [4:0]  ea, eb, e, st;
        logic [10:0] ma, mb, tm;
        logic [11:0] s;
        logic        nx;
        int          d;
        a = ops[15:0]; b = ops[31:16]; c = ops[47:32];
        if (op == 4'd2) begin
            ea = a[14:10]; eb = b[14:10];
            ma = {1'b1, a[9:0]}; mb = {1'b1, b[9:0]};
            if (eb > ea) begin
                e = ea; ea = eb; eb = e;
                tm = ma; ma = mb; mb = tm;
            end
            d = int'(ea) - int'(eb);
            if (d > 11) begin
                nx = 1'b1; mb = '0;
            end else begin
                nx = ((mb & ((11'd1 << d) - 11'd1)) != '0);
                mb = mb >> d;
            end
            s = {1'b0, ma} + {1'b0, mb};
            if (s[11]) begin
                e = ea + 5'd1;
                res = {1'b0, e, s[10:1]};
                nx = nx | s[0];
            end else begin
                res = {1'b0, ea, s[9:0]};
            end
            st = {4'b0, nx};
        end else begin
            res = a ^ {b[7:0], b[15:8]} ^ {op, md, rnd, 8'h00};
            st  = c[4:0];
        end
        return {st, res};
    endfunction

    // FPU output driver: presents one pending result per cycle unless held.
    always @(posedge clk) begin : drv
        int k;
        #2;
        fpu_out_valid_i = 1'b0;
        if (rst_ni && fpu_force) begin
            fpu_out_valid_i = 1'b1;
            fpu_tag_i       = force_tag;
            fpu_result_i    = 16'hDEAD;
            fpu_status_i    = 5'h1F;
        end else if (rst_ni && !fpu_hold && fpu_q.size() > 0) begin
            k = -1;
            if (fpu_pick < 0) k = $urandom_range(fpu_q.size() - 1);
            else foreach (fpu_q[i]) if (int'(fpu_q[i].tag) == fpu_pick) k = i;
            if (k >= 0) begin
                fpu_out_valid_i = 1'b1;
                fpu_tag_i       = fpu_q[k].tag;
                fpu_result_i    = fpu_q[k].res;
                fpu_status_i    = fpu_q[k].st;
                fpu_q.delete(k);
            end
        end
    end

    // Monitor: compare outputs against the model, then advance the model by
    // the events that take effect at the next rising edge.
    always @(negedge clk) begin : mon
        logic [20:0] r, f;
        logic        exp_valid, iv, do_ret;
        logic [4:0]  ret_st;
        int          n;
        if (mon_en) begin
            n = exp_q.size();
            exp_valid = (n > 0) && done_m[exp_q[0].tag];
            iv = cmd_valid_i && (n != DEPTH) && !flush_i;
            chk("in_valid", fpu_in_valid_o, iv);
            chk("cmd_ready", cmd_ready_o, iv && fpu_in_ready_i);
            chk("busy", busy_o, n != 0);
            chk("fflags", fflags_o, ff_m);
            chk("flush_out", fpu_flush_o, flush_i);
            chk("out_ready", fpu_out_ready_o, 1);
            if (iv) chk("tag", fpu_tag_o, tag_m);
            if (!flush_i) begin
                chk("rsp_valid", rsp_valid_o, exp_valid);
                if (exp_valid) begin
                    chk("rsp_result", rsp_result_o, exp_q[0].res);
                    chk("rsp_status", rsp_status_o, exp_q[0].st);
                end
            end
            do_ret = !flush_i && exp_valid && rsp_ready_i;
            ret_st = do_ret ? exp_q[0].st : 5'h00;
            ff_m   = fflags_clr_i ? ret_st : (ff_m | ret_st);
            if (flush_i) begin
                exp_q.delete();
                fpu_q.delete();
                done_m = '0;
                tag_m  = '0;
            end else begin
                if (do_ret) begin
                    done_m[exp_q[0].tag] = 1'b0;
                    void'(exp_q.pop_front());
                end
                if (fpu_out_valid_i)
                    foreach (exp_q[i]) if (exp_q[i].tag == fpu_tag_i) done_m[fpu_tag_i] = 1'b1;
                if (iv && fpu_in_ready_i) begin
                    r = fpu_fn(cmd_operands_i, cmd_op_i, cmd_op_mod_i, cmd_rnd_i);
                    exp_q.push_back('{tag: tag_m, res: r[15:0], st: r[20:16]});
                    f = fpu_fn(fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o);
                    fpu_q.push_back('{tag: fpu_tag_o, res: f[15:0], st: f[20:16]});
                    tag_m = tag_m + 2'd1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [3:0] op);
        cmd_operands_i = {c, b, a};
        cmd_op_i       = op;
        cmd_op_mod_i   = 1'b0;
        cmd_rnd_i      = 3'd0;
        cmd_valid_i    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                step();
                cmd_valid_i = 1'b0;
                return;
            end
            step();
        end
        total++;
        bad++;
        $display("FAIL issue_timeout: got no accept expected accept within 40 cycles at %0t", $time);
        cmd_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: handshake outputs forced low even with requests pending.
        cmd_valid_i = 1'b1;
        flush_i     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_in_valid", fpu_in_valid_o, 0);
        chk("rst_out_ready", fpu_out_ready_o, 0);
        chk("rst_flush_out", fpu_flush_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fflags", fflags_o, 0);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        flush_i     = 1'b0;
        rst_ni      = 1'b1;
        mon_en      = 1'b1;

        // Single add, one-cycle FPU: 1.0 + 2.0 = 3.0.
        fpu_hold = 1'b0;
        issue(16'h3C00, 16'h4000, 16'h0000, 4'd2);
        repeat (4) step();

        // Out-of-order completion, in-order return.
        do_flush();
        fpu_hold = 1'b1;
        issue(16'h1234, 16'h5678, 16'h0000, 4'd3);
        issue(16'h9ABC, 16'hDEF0, 16'h0000, 4'd3);
        fpu_pick = 1; fpu_hold = 1'b0; step();
        fpu_hold = 1'b1; repeat (2) step();
        fpu_pick = 0; fpu_hold = 1'b0; step();
        fpu_hold = 1'b1; repeat (3) step();

        // Full, then wrap once tag 0 retires.
        fpu_pick = -1;
        do_flush();
        for (int i = 0; i < 4; i++) issue(16'(i * 7 + 1), 16'(i * 3 + 5), 16'h0000, 4'd4);
        cmd_operands_i = {16'h0, 16'h1111, 16'h2222};
        cmd_op_i       = 4'd5;
        cmd_valid_i    = 1'b1;
        repeat (2) step();
        fpu_pick = 0; fpu_hold = 1'b0; step();
        fpu_hold = 1'b1;
        issue(16'h2222, 16'h1111, 16'h0000, 4'd5);
        fpu_pick = -1; fpu_hold = 1'b0;
        repeat (10) step();

        // Response backpressure with two completed entries.
        rsp_ready_i = 1'b0;
        issue(16'hAAAA, 16'h5555, 16'h0000, 4'd6);
        issue(16'h0F0F, 16'hF0F0, 16'h0000, 4'd7);
        repeat (5) step();
        rsp_ready_i = 1'b1;
        repeat (3) step();

        // Flush with three outstanding and a result arriving in the flush cycle.
        fpu_hold = 1'b1;
        for (int i = 0; i < 3; i++) issue(16'(i + 100), 16'(i + 200), 16'h0000, 4'd1);
        flush_i = 1'b1; fpu_hold = 1'b0;
        step();
        flush_i = 1'b0; fpu_hold = 1'b1;
        step();
        fpu_hold = 1'b0;
        issue(16'h0001, 16'h0002, 16'h0000, 4'd8);
        repeat (3) step();

        // Spurious result for a tag that is not outstanding is ignored.
        do_flush();
        fpu_hold = 1'b1;
        issue(16'h0101, 16'h0202, 16'h0000, 4'd9);
        force_tag = 2'd1; fpu_force = 1'b1; step();
        fpu_force = 1'b0;
        issue(16'h0303, 16'h0404, 16'h0000, 4'd9);
        fpu_pick = 0; fpu_hold = 1'b0; step();
        fpu_hold = 1'b1; repeat (3) step();
        fpu_pick = -1; fpu_hold = 1'b0; repeat (3) step();

        // Sticky flags, clear, and clear coincident with a retire.
        fflags_clr_i = 1'b1; step(); fflags_clr_i = 1'b0;
        issue(16'h0011, 16'h0022, 16'h0001, 4'd3);
        issue(16'h0033, 16'h0044, 16'h0004, 4'd3);
        repeat (4) step();
        @(negedge clk); chk("fflags_or", fflags_o, 5'h05); step();
        fflags_clr_i = 1'b1; step(); fflags_clr_i = 1'b0;
        @(negedge clk); chk("fflags_clr", fflags_o, 5'h00); step();
        issue(16'h0055, 16'h0066, 16'h0001, 4'd3);
        repeat (3) step();
        rsp_ready_i = 1'b0;
        issue(16'h0077, 16'h0088, 16'h0010, 4'd3);
        repeat (3) step();
        rsp_ready_i = 1'b1; fflags_clr_i = 1'b1; step();
        rsp_ready_i = 1'b0; fflags_clr_i = 1'b0;
        @(negedge clk); chk("fflags_clr_retire", fflags_o, 5'h10); step();
        rsp_ready_i = 1'b1;

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cmd_valid_i    = ($urandom_range(3) != 0);
            cmd_operands_i = {16'($urandom), 16'($urandom), 16'($urandom)};
            cmd_op_i       = 4'($urandom);
            cmd_op_mod_i   = 1'($urandom);
            cmd_rnd_i      = 3'($urandom);
            fpu_in_ready_i = ($urandom_range(3) != 0);
            rsp_ready_i    = ($urandom_range(9) < 7);
            fpu_hold       = ($urandom_range(9) < 3);
            fflags_clr_i   = ($urandom_range(19) == 0);
            flush_i        = ($urandom_range(49) == 0);
            step();
        end
        cmd_valid_i = 1'b0; flush_i = 1'b0; fflags_clr_i = 1'b0;
        fpu_in_ready_i = 1'b1; rsp_ready_i = 1'b1; fpu_hold = 1'b0;
        repeat (20) step();

        // Asynchronous reset mid-operation.
        fpu_hold = 1'b1;
        issue(16'h1357, 16'h2468, 16'h0003, 4'd3);
        issue(16'h8642, 16'h7531, 16'h0005, 4'd3);
        @(posedge clk); #3;
        rst_ni = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("async_busy", busy_o, 0);
        chk("async_rsp_valid", rsp_valid_o, 0);
        chk("async_fflags", fflags_o, 0);
        exp_q.delete(); fpu_q.delete();
        done_m = '0; ff_m = '0; tag_m = '0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        fpu_hold = 1'b0;
        issue(16'h3C00, 16'h3C00, 16'h0000, 4'd2);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpnew_issue_rob.md
# fpnew_issue_rob

Initiator-side issue controller and reorder buffer for an FPnew-based FPU instance. It accepts a command stream from a core or accelerator datapath and allocates a tag per command. It drives the FPU's valid/ready input handshake, collects tagged results from the FPU output handshake in any order, and returns them to the requester strictly in issue order. It also accumulates sticky IEEE exception flags.

## Interface
Parameters:
- FLEN, 16, operand/result width in bits
- TAG_WIDTH, 2, FPU tag width; reorder depth DEPTH = 2**TAG_WIDTH (derived, not overridable)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when both cmd_valid_i and cmd_ready_o are high
- cmd_operands_i  in  3*FLEN  operands {c,b,a}, with a in [FLEN-1:0]
- cmd_op_i  in  4  FPnew operation code, passed through unchanged
- cmd_op_mod_i  in  1  operation modifier, passed through
- cmd_rnd_i  in  3  rounding mode, passed through
- fpu_in_valid_o  out  1  to FPU in_valid_i
- fpu_in_ready_i  in  1  from FPU in_ready_o
- fpu_operands_o / fpu_op_o / fpu_op_mod_o / fpu_rnd_mode_o  out  3*FLEN/4/1/3  combinational copies of cmd_* inputs
- fpu_tag_o  out  TAG_WIDTH  allocated tag
- fpu_flush_o  out  1  to FPU flush_i
- fpu_out_valid_i  in  1  FPU result valid
- fpu_out_ready_o  out  1  to FPU out_ready_i
- fpu_result_i  in  FLEN  FPU result
- fpu_status_i  in  5  {NV,DZ,OF,UF,NX}
- fpu_tag_i  in  TAG_WIDTH  result tag
- rsp_valid_o  out  1  in-order response available
- rsp_ready_i  in  1  response consumed on valid&ready
- rsp_result_o  out  FLEN  response data
- rsp_status_o  out  5  response status
- flush_i  in  1  discard all outstanding work
- fflags_o  out  5  sticky OR of retired rsp_status_o
- fflags_clr_i  in  1  clear fflags_o
- busy_o  out  1  at least one entry outstanding

## Operation
- State:
  - head and tail pointers, each TAG_WIDTH+1 bits; count = tail - head (mod 2^(TAG_WIDTH+1)).
  - Per-entry done bit, result register and status register.
  - fflags register.
- Issue:
  - fpu_in_valid_o = cmd_valid_i & (count != DEPTH) & !flush_i.
  - cmd_ready_o = fpu_in_valid_o-conditions & fpu_in_ready_i. It never depends on rsp_ready_i, and there is no full-and-pop bypass.
  - fpu_tag_o = tail[TAG_WIDTH-1:0]. On handshake, tail increments.
- Completion:
  - fpu_out_ready_o = 1 outside reset, because a slot is always reserved.
  - On fpu_out_valid_i, entry fpu_tag_i captures result and status and sets done.
  - A result whose tag is not currently outstanding is dropped, with no state change.
- Retire:
  - rsp_valid_o = done[head]. rsp_result_o and rsp_status_o come from the head entry.
  - On rsp handshake, done[head] clears, head increments, and fflags |= rsp_status_o.
- fflags_clr_i has priority over the OR from the same cycle's retire: fflags <= the status of the retire in that cycle if one occurs, else 0.
- Flush:
  - fpu_flush_o = flush_i, combinationally.
  - In the flush cycle: no issue, no retire, and any arriving result is dropped.
  - Next edge: head = tail = 0 and all done bits = 0. fflags is unaffected.
- busy_o = (count != 0).
- Simultaneous events:
  - Issue, completion and retire in the same cycle all take effect.
  - A completion for the head entry produces rsp_valid_o on the next cycle, not the same cycle.
  - Wrap-around: pointers wrap modulo 2^(TAG_WIDTH+1), and tags wrap modulo DEPTH.

## Timing
- Reset state:
  - head = tail = 0, done = 0, fflags = 0.
  - Outputs: rsp_valid_o = 0, busy_o = 0, fflags_o = 0.
  - cmd_ready_o, fpu_in_valid_o, fpu_out_ready_o and fpu_flush_o are forced to 0 while rst_ni is low.
- Reset asserted mid-operation discards all entries immediately (asynchronous).
- Issue path is combinational: a command accepted in cycle N appears at the FPU in cycle N.
- An FPU result in cycle M produces rsp_valid_o in cycle M+1. With a 1-stage FPU, the minimum cmd-to-rsp latency is 2 cycles.
- Throughput is 1 command per cycle while count < DEPTH.
- Response outputs stay stable while rsp_valid_o & !rsp_ready_i.

## Test plan
- Single add, FLEN=16, FPU model latency 1: a=0x3C00, b=0x4000, op=ADD, rnd=RNE accepted at cycle N -> fpu_tag_o=0; rsp_valid_o at N+2 with rsp_result_o=0x4200, rsp_status_o=0; busy_o falls after retire.
- Out-of-order: issue tags 0 and 1; model returns tag 1 then tag 0 -> tag-0 response first, then tag-1, each with the matching result.
- Full: model withholds results, 4 commands issued -> 5th sees cmd_ready_o=0 and fpu_in_valid_o=0. Release tag 0 and retire it -> 5th accepted the following cycle with fpu_tag_o=0 (wrap).
- Backpressure: rsp_ready_i=0 for 5 cycles with 2 completed entries -> rsp_valid_o=1 and outputs stable; raising rsp_ready_i drains them in order on consecutive cycles.
- Flush with 3 outstanding and a result arriving in the flush cycle -> fpu_flush_o=1 in that cycle; next cycle busy_o=0 and rsp_valid_o=0; next command gets fpu_tag_o=0.
- fflags:
  - Retire status 0x01 then 0x04 -> fflags_o=0x05.
  - fflags_clr_i alone -> 0x00.
  - fflags_clr_i coincident with a retire of status 0x10 -> 0x10.
